// File: rtl/walk_sequencer_pkg.sv
// Shared types and constants for the detector walk sequencer.
// Holds the walk state encoding and the detector drive/result values.
package walk_sequencer_pkg;

    typedef enum logic [2:0] {
        W_IDLE,
        W_CLEAR,
        W_ARM,
        W_LOAD,
        W_PAIR,
        W_FIRE,
        W_DONE
    } walk_state_t;

    localparam logic [3:0] WALK_D_LOAD    = 4'b0010;
    localparam logic [3:0] WALK_D_FIRE    = 4'b1000;
    localparam logic [7:0] WALK_Q_PAIR_C1 = 8'hFF;
    localparam logic [7:0] WALK_Q_PAIR_C0 = 8'h54;

endpackage

// File: rtl/walk_rr_arbiter.sv
// Request arbiter for the walk sequencer; one-hot grant from a request vector.
// Ports: i_clk, i_rst (sync, active high), i_req, i_update (advance pointer),
// o_gnt (one-hot or zero). WALK_SEQ_RR_EN selects round-robin, else fixed
// lowest-index priority with no pointer state.
module walk_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_update,
    output logic [NREQ-1:0] o_gnt
);

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

`ifdef WALK_SEQ_RR_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_next;
    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_rot_gnt;

    // Rotate so the pointer slot is bit 0, pick lowest set bit, rotate back.
    always_comb begin
        w_rot     = NREQ'({i_req, i_req} >> r_ptr);
        w_rot_gnt = w_rot & (~w_rot + ONE);
        o_gnt     = NREQ'(({w_rot_gnt, w_rot_gnt} << r_ptr) >> NREQ);
    end

    always_comb begin
        w_ptr_next = r_ptr;
        for (int j = 0; j < NREQ; j++) begin
            if (o_gnt[j]) begin
                w_ptr_next = PW'((j + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_update) begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    logic w_unused;
    assign w_unused = i_clk ^ i_rst ^ i_update;

    // Isolate the lowest set request bit.
    assign o_gnt = i_req & (~i_req + ONE);
`endif

endmodule

// File: rtl/walk_sequencer.sv
// Shares one pattern detector among NREQ requesters, walking it S0..S4 per grant.
// Ports: clk, rst (sync, active high), req/cflag in, gnt/done/result/busy out,
// detector drives dA/dB/dC/dD/dRstN out, detector output dQ in.
// Arbitration is round-robin when WALK_SEQ_RR_EN is defined, else fixed priority.
module walk_sequencer
    import walk_sequencer_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] cflag,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic [7:0]      result,
    output logic            busy,
    output logic            dA,
    output logic            dB,
    output logic            dC,
    output logic [3:0]      dD,
    output logic            dRstN,
    input  logic [7:0]      dQ
);

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    walk_state_t     r_state;
    walk_state_t     w_next;
    walk_state_t     w_after;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_arb_gnt;
    logic            r_cf;
    logic [7:0]      r_result;
    logic            w_take;
    logic            w_cap;
    logic            w_phase;
    logic            w_last;

    walk_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_update (w_take),
        .o_gnt    (w_arb_gnt)
    );

    assign w_last = (r_cnt == ONE_C);
    assign result = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= W_IDLE;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_cf     <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_take) begin
                r_gnt <= w_arb_gnt;
                r_cf  <= |(cflag & w_arb_gnt);
            end
            if (w_cap) begin
                r_result <= dQ;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_after    = W_IDLE;
        w_cnt_next = r_cnt;
        w_take     = 1'b0;
        w_cap      = 1'b0;
        w_phase    = 1'b0;
        gnt        = r_gnt;
        done       = '0;
        busy       = 1'b1;
        dA         = 1'b0;
        dB         = 1'b0;
        dC         = 1'b0;
        dD         = '0;
        dRstN      = 1'b1;
        unique case (r_state)
            W_IDLE: begin
                gnt  = '0;
                busy = 1'b0;
                if (|req) begin
                    w_take = 1'b1;
                    w_next = W_CLEAR;
                end
            end
            W_CLEAR: begin
                dRstN      = 1'b0;
                w_next     = W_ARM;
                w_cnt_next = HOLD_C;
            end
            W_ARM: begin
                dA      = 1'b1;
                dC      = r_cf;
                w_phase = 1'b1;
                w_after = W_LOAD;
            end
            W_LOAD: begin
                dD      = WALK_D_LOAD;
                dC      = r_cf;
                w_phase = 1'b1;
                w_after = W_PAIR;
            end
            W_PAIR: begin
                dA      = 1'b1;
                dB      = 1'b1;
                dC      = r_cf;
                w_phase = 1'b1;
                w_after = W_FIRE;
                // Detector sits in S2 with A&B only during the first cycle.
                w_cap   = (r_cnt == HOLD_C);
            end
            W_FIRE: begin
                dD      = WALK_D_FIRE;
                dC      = r_cf;
                w_phase = 1'b1;
                w_after = W_DONE;
            end
            W_DONE: begin
                done   = r_gnt;
                w_next = W_IDLE;
            end
            default: begin
                gnt    = '0;
                busy   = 1'b0;
                w_next = W_IDLE;
            end
        endcase
        if (w_phase) begin
            if (w_last) begin
                w_next     = w_after;
                w_cnt_next = HOLD_C;
            end else begin
                w_cnt_next = r_cnt - ONE_C;
            end
        end
    end

endmodule

// File: tb/tb_walk_sequencer.sv
// Bench for walk_sequencer: HOLD=1 and HOLD=3 instances, each with a detector.
// Outputs are compared every cycle against a timeline model plus literal checks.
module tb_walk_sequencer;

    localparam int N  = 2;
    localparam int H0 = 1;
    localparam int H1 = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] cflag = '0;

    logic [N-1:0] gnt_w [2];
    logic [N-1:0] done_w [2];
    logic [7:0]   res_w [2];
    logic         busy_w [2];
    logic         dA_w [2];
    logic         dB_w [2];
    logic         dC_w [2];
    logic [3:0]   dD_w [2];
    logic         dRstN_w [2];
    logic [7:0]   dq_w [2];

    int ds [2];
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    walk_sequencer #(.NREQ(N), .HOLD(H0)) u0 (
        .clk(clk), .rst(rst), .req(req), .cflag(cflag),
        .gnt(gnt_w[0]), .done(done_w[0]), .result(res_w[0]),
        .busy(busy_w[0]), .dA(dA_w[0]), .dB(dB_w[0]), .dC(dC_w[0]),
        .dD(dD_w[0]), .dRstN(dRstN_w[0]), .dQ(dq_w[0])
    );

    walk_sequencer #(.NREQ(N), .HOLD(H1)) u1 (
        .clk(clk), .rst(rst), .req(req), .cflag(cflag),
        .gnt(gnt_w[1]), .done(done_w[1]), .result(res_w[1]),
        .busy(busy_w[1]), .dA(dA_w[1]), .dB(dB_w[1]), .dC(dC_w[1]),
        .dD(dD_w[1]), .dRstN(dRstN_w[1]), .dQ(dq_w[1])
    );

    // Pattern detector: S0 -A-> S1 -D=2-> S2 -A&B-> S3 -D=8-> S4 -> S0.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!dRstN_w[i]) ds[i] <= 0;
            else begin
                case (ds[i])
                    0: if (dA_w[i]) ds[i] <= 1;
                    1: if (dD_w[i] == 4'd2) ds[i] <= 2;
                    2: if (dA_w[i] && dB_w[i]) ds[i] <= 3;
                    3: if (dD_w[i] == 4'd8) ds[i] <= 4;
                    default: if (dD_w[i] != 4'd8) ds[i] <= 0;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dq_w[i] = {5'b0, 3'(ds[i])};
            if (ds[i] == 2 && dA_w[i] && dB_w[i])
                dq_w[i] = dC_w[i] ? 8'hFF : 8'h54;
        end
    end

    // Inputs as seen by the DUT at each rising edge.
    logic         s_rst = 1'b1;
    logic [N-1:0] s_req = '0;
    logic [N-1:0] s_cf = '0;
    always @(posedge clk) begin
        s_rst <= rst;
        s_req <= req;
        s_cf  <= cflag;
    end

    // Model: a walk is a timeline of offsets k since the sampled request.
    bit       m_act [2] = '{0, 0};
    int       m_k [2] = '{0, 0};
    int       m_g [2] = '{0, 0};
    bit       m_cf [2] = '{0, 0};
    int       m_ptr [2] = '{0, 0};
    logic [7:0] m_res [2] = '{8'h00, 8'h00};

    task automatic model_step(input int i);
        int hh;
        int idx;
        hh = (i == 0) ? H0 : H1;
        if (s_rst) begin
            m_act[i] = 0;
            m_k[i] = 0;
            m_res[i] = 8'h00;
            m_ptr[i] = 0;
        end else if (!m_act[i]) begin
            if (s_req != 0) begin
                for (int j = N - 1; j >= 0; j--) begin
                    idx = (m_ptr[i] + j) % N;
                    if (s_req[idx]) m_g[i] = idx;
                end
                m_act[i] = 1;
                m_k[i] = 1;
                m_cf[i] = s_cf[m_g[i]];
`ifdef WALK_SEQ_RR_EN
                m_ptr[i] = (m_g[i] + 1) % N;
`endif
            end
        end else begin
            m_k[i]++;
            if (m_k[i] == 3 + 2 * hh)
                m_res[i] = m_cf[i] ? 8'hFF : 8'h54;
            if (m_k[i] == 3 + 4 * hh)
                m_act[i] = 0;
        end
    endtask

    function automatic logic [20:0] model_out(input int i);
        int hh;
        int p;
        logic [N-1:0] g, d;
        logic b, a, bb, c, rn;
        logic [3:0] dd;
        hh = (i == 0) ? H0 : H1;
        g = '0; d = '0; b = 0; a = 0; bb = 0; c = 0; dd = '0; rn = 1;
        if (m_act[i]) begin
            g = N'(1) << m_g[i];
            b = 1;
            if (m_k[i] == 1) rn = 0;
            if (m_k[i] == 2 + 4 * hh) d = g;
            if (m_k[i] >= 2 && m_k[i] < 2 + 4 * hh) begin
                p = (m_k[i] - 2) / hh;
                a = (p == 0 || p == 2);
                bb = (p == 2);
                dd = (p == 1) ? 4'd2 : (p == 3) ? 4'd8 : 4'd0;
                c = m_cf[i];
            end
        end
        return {g, d, b, m_res[i], a, bb, c, dd, rn};
    endfunction

    initial begin
        logic [20:0] got, exp;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                model_step(i);
                exp = model_out(i);
                got = {gnt_w[i], done_w[i], busy_w[i], res_w[i], dA_w[i],
                       dB_w[i], dC_w[i], dD_w[i], dRstN_w[i]};
                nchk++;
                if (got !== exp) begin
                    nerr++;
                    $display("FAIL cycle_cmp inst%0d t=%0t got %h expected %h",
                             i, $time, got, exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s got %h expected %h", nm, a, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic walk_single(input logic cf, input logic [7:0] exp);
        req = 2'b01;
        cflag = {1'b0, cf};
        step(1);
        req = 2'b00;
        chk("single_gnt", 32'(gnt_w[0]), 32'h1);
        step(2);
        chk("single_load_dD", 32'(dD_w[0]), 32'h2);
        step(2);
        chk("single_fire_dD", 32'(dD_w[0]), 32'h8);
        step(1);
        chk("single_done", 32'(done_w[0]), 32'h1);
        chk("single_result", 32'(res_w[0]), 32'(exp));
        step(1);
        chk("det_back_s0", 32'(ds[0]), 32'h0);
        step(9);
    endtask

    initial begin
        step(3);
        chk("rst_gnt", 32'(gnt_w[0]), 32'h0);
        chk("rst_result", 32'(res_w[0]), 32'h0);
        chk("rst_dRstN", 32'(dRstN_w[0]), 32'h1);
        rst = 1'b0;
        step(1);

        // Two back-to-back walks with both requesting.
        req = 2'b11;
        cflag = 2'b11;
        step(1);
        chk("dual_first_gnt", 32'(gnt_w[0]), 32'h1);
        step(7);
`ifdef WALK_SEQ_RR_EN
        chk("dual_second_gnt", 32'(gnt_w[0]), 32'h2);
`else
        chk("dual_second_gnt", 32'(gnt_w[0]), 32'h1);
`endif
        req = 2'b00;
        step(20);

        walk_single(1'b1, 8'hFF);
        walk_single(1'b0, 8'h54);

        // HOLD=3 walk on requester 1.
        req = 2'b10;
        cflag = 2'b10;
        step(1);
        req = 2'b00;
        chk("h3_gnt", 32'(gnt_w[1]), 32'h2);
        step(4);
        chk("h3_load_first", 32'(dD_w[1]), 32'h2);
        step(2);
        chk("h3_load_last", 32'(dD_w[1]), 32'h2);
        step(1);
        chk("h3_pair_dA", 32'(dA_w[1]), 32'h1);
        step(5);
        chk("h3_no_early_done", 32'(done_w[1]), 32'h0);
        step(1);
        chk("h3_done", 32'(done_w[1]), 32'h2);
        chk("h3_result", 32'(res_w[1]), 32'hFF);
        step(3);

        // Reset during W_PAIR of the HOLD=1 instance.
        req = 2'b01;
        cflag = 2'b01;
        step(1);
        req = 2'b00;
        step(3);
        chk("pre_rst_pair", 32'(dB_w[0]), 32'h1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_mid_gnt", 32'(gnt_w[0]), 32'h0);
        chk("rst_mid_done", 32'(done_w[0]), 32'h0);
        chk("rst_mid_result", 32'(res_w[0]), 32'h0);
        chk("rst_mid_busy", 32'(busy_w[0]), 32'h0);
        step(2);
        walk_single(1'b1, 8'hFF);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            req = N'($urandom_range(0, 3));
            cflag = N'($urandom_range(0, 3));
            rst = ($urandom_range(0, 63) == 0);
            step(1);
        end
        rst = 1'b0;
        req = '0;
        step(20);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
